// File: rtl/example_mul_acc_pipe_if.sv
// rtl/example_mul_acc_pipe_if.sv - input/output beat handshake bundle for the multiply-accumulate pipe
interface example_mul_acc_pipe_if #(
  parameter int A_WIDTH   = 14,
  parameter int B_WIDTH   = 9,
  parameter int OUT_WIDTH = 21
);
  logic                 in_valid;
  logic                 in_ready;
  logic [A_WIDTH-1:0]   in_a;
  logic [B_WIDTH-1:0]   in_b;
  logic                 in_acc;
  logic                 in_first;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_sat;

  modport master (
    output in_valid, in_a, in_b, in_acc, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_a, in_b, in_acc, in_first, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/example_mul_acc_pipe.sv
// rtl/example_mul_acc_pipe.sv - pipelined signed x unsigned multiplier with framed wrapping accumulator
module example_mul_acc_pipe #(
  parameter int A_WIDTH   = 14,
  parameter int B_WIDTH   = 9,
  parameter int NUM_STAGE = 3,
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 21,
  parameter int SATURATE  = 1
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
  example_mul_acc_pipe_if.slave bus
);
  localparam int P_WIDTH = A_WIDTH + B_WIDTH;
  localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MAX = ~OUT_MIN;

  logic                        en;
  logic                        out_valid_q;
  logic [OUT_WIDTH-1:0]        out_data_q;
  logic                        out_sat_q;
  logic signed [ACC_WIDTH-1:0] acc_r;

  logic signed [P_WIDTH-1:0]   a_ext;
  logic signed [P_WIDTH-1:0]   b_ext;
  logic signed [P_WIDTH-1:0]   prod;
  logic signed [ACC_WIDTH-1:0] p_in;

  logic signed [ACC_WIDTH-1:0] fin_p;
  logic                        fin_valid;
  logic                        fin_acc;
  logic                        fin_first;
  logic                        fin_last;

  assign en           = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

  // The product of a signed A-bit and an unsigned B-bit value always fits in A+B signed bits.
  assign a_ext = {{B_WIDTH{bus.in_a[A_WIDTH-1]}}, bus.in_a};
  assign b_ext = {{A_WIDTH{1'b0}}, bus.in_b};
  assign prod  = a_ext * b_ext;
  assign p_in  = ACC_WIDTH'(prod);

  generate
    if (NUM_STAGE > 1) begin : g_pipe
      localparam int D = NUM_STAGE - 1;
      logic signed [ACC_WIDTH-1:0] st_p [D];
      logic [D-1:0]                st_v;
      logic [D-1:0]                st_acc;
      logic [D-1:0]                st_first;
      logic [D-1:0]                st_last;

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          st_v     <= '0;
          st_acc   <= '0;
          st_first <= '0;
          st_last  <= '0;
          for (int i = 0; i < D; i++) st_p[i] <= '0;
        end else if (en) begin
          st_p[0]     <= p_in;
          st_v[0]     <= bus.in_valid;
          st_acc[0]   <= bus.in_acc;
          st_first[0] <= bus.in_first;
          st_last[0]  <= bus.in_last;
          for (int i = 1; i < D; i++) begin
            st_p[i]     <= st_p[i-1];
            st_v[i]     <= st_v[i-1];
            st_acc[i]   <= st_acc[i-1];
            st_first[i] <= st_first[i-1];
            st_last[i]  <= st_last[i-1];
          end
        end
      end

      assign fin_p     = st_p[D-1];
      assign fin_valid = st_v[D-1];
      assign fin_acc   = st_acc[D-1];
      assign fin_first = st_first[D-1];
      assign fin_last  = st_last[D-1];
    end else begin : g_direct
      assign fin_p     = p_in;
      assign fin_valid = bus.in_valid;
      assign fin_acc   = bus.in_acc;
      assign fin_first = bus.in_first;
      assign fin_last  = bus.in_last;
    end
  endgenerate

  logic signed [ACC_WIDTH-1:0] acc_sum;
  logic signed [ACC_WIDTH-1:0] res;
  logic signed [ACC_WIDTH-1:0] res_sext;
  logic [OUT_WIDTH-1:0]        res_trunc;
  logic                        res_fits;
  logic [OUT_WIDTH-1:0]        conv_data;
  logic                        emit;

  assign acc_sum   = fin_first ? fin_p : acc_r + fin_p;
  assign res       = fin_acc ? acc_sum : fin_p;
  assign res_trunc = res[OUT_WIDTH-1:0];
  assign res_sext  = ACC_WIDTH'($signed(res_trunc));
  // A value fits exactly when it survives truncation; that is also the clamp condition.
  assign res_fits  = (res == res_sext);
  assign conv_data = (SATURATE != 0 && !res_fits) ? (res[ACC_WIDTH-1] ? OUT_MIN : OUT_MAX)
                                                  : res_trunc;
  assign emit      = fin_valid && (!fin_acc || fin_last);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_r       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (en) begin
      out_valid_q <= emit;
      if (fin_valid && fin_acc) acc_r <= acc_sum;
      if (emit) begin
        out_data_q <= conv_data;
        out_sat_q  <= !res_fits;
      end
    end
  end
endmodule

// File: tb/tb_example_mul_acc_pipe.sv
// tb/tb_example_mul_acc_pipe.sv - randomized self-checking bench for example_mul_acc_pipe
module tb_example_mul_acc_pipe;
  localparam int AW  = 14;
  localparam int BW  = 9;
  localparam int NS  = 3;
  localparam int ACW = 32;
  localparam int OW  = 21;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  example_mul_acc_pipe_if #(.A_WIDTH(AW), .B_WIDTH(BW), .OUT_WIDTH(OW)) bus0 ();
  example_mul_acc_pipe_if #(.A_WIDTH(AW), .B_WIDTH(BW), .OUT_WIDTH(OW)) bus1 ();

  example_mul_acc_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .NUM_STAGE(NS), .ACC_WIDTH(ACW),
                         .OUT_WIDTH(OW), .SATURATE(1))
    dut_sat (.ap_clk(clk), .ap_rst_n(rst_n), .bus(bus0));

  example_mul_acc_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .NUM_STAGE(NS), .ACC_WIDTH(ACW),
                         .OUT_WIDTH(OW), .SATURATE(0))
    dut_trn (.ap_clk(clk), .ap_rst_n(rst_n), .bus(bus1));

  int total = 0;
  int bad   = 0;
  int m_acc = 0;
  logic [OW:0] exp0[$];
  logic [OW:0] obs0[$];
  logic [OW:0] obs1[$];

  always @(negedge clk) begin
    if (rst_n && bus0.out_valid && bus0.out_ready) obs0.push_back({bus0.out_sat, bus0.out_data});
    if (rst_n && bus1.out_valid && bus1.out_ready) obs1.push_back({bus1.out_sat, bus1.out_data});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Reference conversion: clamp or wrap a mathematical integer into OW signed bits.
  function automatic logic [OW:0] model_conv(longint v, bit sat_mode);
    longint hi;
    longint lo;
    longint t;
    hi = (longint'(1) <<< (OW - 1)) - 1;
    lo = -hi - 1;
    if (sat_mode) begin
      if (v > hi) return {1'b1, OW'(hi)};
      if (v < lo) return {1'b1, OW'(lo)};
      return {1'b0, OW'(v)};
    end
    t = v & ((longint'(1) <<< OW) - 1);
    if (t > hi) t = t - (longint'(1) <<< OW);
    return {(t != v), OW'(t)};
  endfunction

  task automatic drive_beat(input int a, input int b, input bit acc, input bit first, input bit last);
    longint p;
    bit accepted;
    p = longint'(a) * longint'(b);
    if (!acc) exp0.push_back(model_conv(p, 1'b1));
    else begin
      m_acc = first ? int'(p) : int'(longint'(m_acc) + p);
      if (last) exp0.push_back(model_conv(longint'(m_acc), 1'b1));
    end
    bus0.in_a = AW'(a);
    bus0.in_b = BW'(b);
    bus0.in_acc = acc;
    bus0.in_first = first;
    bus0.in_last = last;
    bus0.in_valid = 1'b1;
    accepted = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (bus0.in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 want in_ready=1 within 1000 cycles");
    end
    @(posedge clk);
    #1;
    bus0.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus0.in_valid = 0; bus0.in_a = '0; bus0.in_b = '0; bus0.in_acc = 0;
    bus0.in_first = 0; bus0.in_last = 0; bus0.out_ready = 1;
    bus1.in_valid = 0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_acc = 0;
    bus1.in_first = 0; bus1.in_last = 0; bus1.out_ready = 1;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus0.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus0.out_valid); end
    total++; if (bus0.out_data !== '0) begin bad++; $display("FAIL reset_out_data: got %0d want 0", bus0.out_data); end
    total++; if (bus0.out_sat !== 1'b0) begin bad++; $display("FAIL reset_out_sat: got %b want 0", bus0.out_sat); end
    total++; if (bus0.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus0.in_ready); end
    total++; if (bus1.out_valid !== 1'b0) begin bad++; $display("FAIL reset_trn_out_valid: got %b want 0", bus1.out_valid); end
    @(negedge clk);
    rst_n = 1;
    m_acc = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mul_latency();
    int n;
    exp0.delete(); obs0.delete();
    drive_beat(100, 200, 0, 0, 0);
    n = 1;
    while (!bus0.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++; if (n != NS) begin bad++; $display("FAIL mul_latency: got %0d want %0d", n, NS); end
    total++; if (bus0.out_data !== OW'(20000)) begin bad++; $display("FAIL mul_data: got %0d want 20000", $signed(bus0.out_data)); end
    total++; if (bus0.out_sat !== 1'b0) begin bad++; $display("FAIL mul_sat: got %b want 0", bus0.out_sat); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (obs0.size() != 1) begin bad++; $display("FAIL mul_count: got %0d want 1", obs0.size()); end
  endtask

  task automatic test_saturation();
    logic [OW:0] want_lo;
    logic [OW:0] want_hi;
    want_lo = {1'b1, OW'(-1048576)};
    want_hi = {1'b1, OW'(1048575)};
    exp0.delete(); obs0.delete();
    drive_beat(-8192, 511, 0, 0, 0);
    drive_beat(8191, 511, 0, 0, 0);
    for (int k = 0; k < 50 && obs0.size() < 2; k++) begin @(posedge clk); #1; end
    total++;
    if (obs0.size() != 2) begin bad++; $display("FAIL sat_count: got %0d want 2", obs0.size()); end
    else begin
      total++; if (obs0[0] !== want_lo) begin bad++; $display("FAIL sat_neg: got %h want %h", obs0[0], want_lo); end
      total++; if (obs0[1] !== want_hi) begin bad++; $display("FAIL sat_pos: got %h want %h", obs0[1], want_hi); end
    end
  endtask

  task automatic test_truncate();
    logic [OW:0] want;
    want = {1'b1, OW'(-8703)};
    obs1.delete();
    bus1.in_a = AW'(8191); bus1.in_b = BW'(511); bus1.in_acc = 0;
    bus1.in_first = 0; bus1.in_last = 0; bus1.in_valid = 1;
    @(posedge clk);
    #1;
    bus1.in_valid = 0;
    for (int k = 0; k < 50 && obs1.size() < 1; k++) begin @(posedge clk); #1; end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs1.size() != 1) begin bad++; $display("FAIL trunc_count: got %0d want 1", obs1.size()); end
    else begin
      total++; if (obs1[0] !== want) begin bad++; $display("FAIL trunc_value: got %h want %h", obs1[0], want); end
    end
  endtask

  task automatic test_accumulate();
    logic [OW:0] want;
    want = {1'b0, OW'(24)};
    exp0.delete(); obs0.delete();
    drive_beat(10, 3, 1, 1, 0);
    drive_beat(-4, 5, 1, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    total++; if (obs0.size() != 0) begin bad++; $display("FAIL acc_no_early_out: got %0d outputs want 0", obs0.size()); end
    drive_beat(7, 2, 1, 0, 1);
    for (int k = 0; k < 50 && obs0.size() < 1; k++) begin @(posedge clk); #1; end
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (obs0.size() != 1) begin bad++; $display("FAIL acc_count: got %0d want 1", obs0.size()); end
    else begin
      total++; if (obs0[0] !== want) begin bad++; $display("FAIL acc_value: got %h want %h", obs0[0], want); end
    end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] held;
    exp0.delete(); obs0.delete();
    bus0.out_ready = 1;
    fork
      begin
        for (int i = 1; i <= 8; i++) drive_beat(i, 2, 0, 0, 0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        bus0.out_ready = 0;
        held = bus0.out_data;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          total++; if (bus0.out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid: got %b want 1", bus0.out_valid); end
          total++; if (bus0.out_data !== held) begin bad++; $display("FAIL stall_stable: got %0d want %0d", bus0.out_data, held); end
          total++; if (bus0.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready: got %b want 0", bus0.in_ready); end
        end
        @(posedge clk);
        #1;
        bus0.out_ready = 1;
        @(negedge clk);
        total++; if (bus0.in_ready !== 1'b1) begin bad++; $display("FAIL resume_in_ready: got %b want 1", bus0.in_ready); end
      end
    join
    for (int k = 0; k < 100 && obs0.size() < 8; k++) begin @(posedge clk); #1; end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (obs0.size() != 8) begin bad++; $display("FAIL b2b_count: got %0d want 8", obs0.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (obs0[i] !== {1'b0, OW'(2 * (i + 1))}) begin
          bad++; $display("FAIL b2b_value[%0d]: got %h want %0d", i, obs0[i], 2 * (i + 1));
        end
      end
    end
  endtask

  task automatic test_random();
    bit done;
    done = 0;
    exp0.delete(); obs0.delete();
    fork
      begin
        for (int i = 0; i < 120; i++) begin
          drive_beat(int'($urandom_range(16383)) - 8192, int'($urandom_range(511)),
                     bit'($urandom_range(1)), ($urandom_range(3) == 0), ($urandom_range(2) == 0));
          if ($urandom_range(3) == 0) begin @(posedge clk); #1; end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus0.out_ready = ($urandom_range(9) < 7);
        end
        bus0.out_ready = 1;
      end
    join
    for (int k = 0; k < 400 && obs0.size() < exp0.size(); k++) begin @(posedge clk); #1; end
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (obs0.size() != exp0.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", obs0.size(), exp0.size()); end
    for (int i = 0; i < obs0.size() && i < exp0.size(); i++) begin
      total++;
      if (obs0[i] !== exp0[i]) begin bad++; $display("FAIL rand_value[%0d]: got %h want %h", i, obs0[i], exp0[i]); end
    end
  endtask

  task automatic test_reset_midchain();
    logic [OW:0] want;
    want = {1'b0, OW'(26)};
    exp0.delete(); obs0.delete();
    bus0.out_ready = 0;
    drive_beat(3, 4, 1, 1, 0);
    drive_beat(2, 2, 1, 0, 0);
    drive_beat(1, 1, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    total++; if (bus0.out_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid: got %b want 1", bus0.out_valid); end
    #2;
    rst_n = 0;
    #1;
    total++; if (bus0.out_valid !== 1'b0) begin bad++; $display("FAIL async_reset_valid: got %b want 0", bus0.out_valid); end
    total++; if (bus0.out_data !== '0) begin bad++; $display("FAIL async_reset_data: got %0d want 0", bus0.out_data); end
    @(posedge clk);
    #3;
    rst_n = 1;
    m_acc = 0;
    exp0.delete(); obs0.delete();
    bus0.out_ready = 1;
    @(posedge clk);
    #1;
    drive_beat(5, 5, 1, 1, 0);
    drive_beat(1, 1, 1, 0, 1);
    for (int k = 0; k < 50 && obs0.size() < 1; k++) begin @(posedge clk); #1; end
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (obs0.size() != 1) begin bad++; $display("FAIL midchain_count: got %0d want 1", obs0.size()); end
    else begin
      total++; if (obs0[0] !== want) begin bad++; $display("FAIL midchain_value: got %h want %h", obs0[0], want); end
    end
  endtask

  initial begin
    test_reset();
    test_mul_latency();
    test_saturation();
    test_truncate();
    test_accumulate();
    test_back_to_back();
    test_random();
    test_reset_midchain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
